lif_potential_accumulator: RTL
==============================

Name: lif_potential_accumulator

Overview:
- Sequential LIF membrane-potential stage wrapped around the team's combinational FP32 Addition_Subtraction unit.
- Drives the adder's operands and consumes its result and Exception output.
- Integrates a stream of weighted FP32 input spikes into a membrane potential, applies a leak at each timestep boundary, and compares against a threshold.
- Emits an output spike, a potential reset, and a refractory period; sits between the spike/weight fetch logic and the accelerator's spike router.

Parameters:
THRESHOLD  32'h3F800000  FP32 firing threshold (1.0); must be positive
LEAK  32'h3DCCCCCD  FP32 leak magnitude per timestep (0.1); positive
V_RESET  32'h00000000  FP32 potential loaded after a spike
REFRAC_STEPS  2  timesteps of refractory period after a spike
REFRAC_W  4  refractory counter width; must hold REFRAC_STEPS

Ports:
CLK  input  1  clock, rising edge
RESET_N  input  1  asynchronous active-low reset
in_valid  input  1  weight present
in_ready  output  1  accumulator can accept a weight this cycle
in_weight  input  32  FP32 synaptic weight
in_excit  input  1  1 = add weight, 0 = subtract weight
step_end  input  1  one-cycle timestep-boundary pulse
adder_a  output  32  adder operand A
adder_b  output  32  adder operand B
adder_sub  output  1  adder AddBar_Sub (1 = A-B)
adder_result  input  32  adder result, combinational, same cycle
adder_exception  input  1  adder Exception, same cycle
spike_out  output  1  registered one-cycle output spike
step_done  output  1  registered one-cycle timestep-complete pulse
v_mem  output  32  current membrane potential register
exc_flag  output  1  sticky: adder exception seen
overrun_flag  output  1  sticky: step_end dropped

Behaviour:
Reset (RESET_N low, async, any state):
- v_mem=V_RESET, state=IDLE, refrac_cnt=0, pending=0.
- spike_out, step_done, exc_flag, overrun_flag all 0.

States:
- IDLE: accepts weights.
- LEAK: applies the leak.
- CHECK: threshold compare and refractory handling.

in_ready:
- in_ready = (state==IDLE) && !step_end && !pending.
- step_end has priority over a same-cycle weight; the weight waits.

Adder drive (combinational):
- IDLE with in_valid&&in_ready: a=v_mem, b=in_weight, sub=~in_excit.
- LEAK: a=v_mem, b=LEAK, sub=~v_mem[31].
- Otherwise: a=v_mem, b=0, sub=0.

Accumulate (IDLE, handshake):
- If refrac_cnt==0 and !adder_exception: v_mem<=adder_result at the same edge. Throughput is 1 weight/cycle.
- If refrac_cnt!=0: weight is consumed and discarded.
- If adder_exception: v_mem is held and exc_flag<=1.

Step transition:
- step_end (or pending) sampled in IDLE → LEAK next cycle; pending<=0.

LEAK (1 cycle):
- v_mem==32'h0 or 32'h80000000, or refrac_cnt!=0: v_mem unchanged.
- Otherwise v_mem<=adder_result, clamped to 32'h0 if the result sign differs from the old v_mem sign.
- adder_exception: v_mem held, exc_flag<=1.
- → CHECK.

CHECK (1 cycle):
- fire = refrac_cnt==0 && v_mem[31]==0 && v_mem[30:0] >= THRESHOLD[30:0] (unsigned).
- If fire: v_mem<=V_RESET, refrac_cnt<=REFRAC_STEPS, spike_out<=1.
- Else if refrac_cnt!=0: refrac_cnt<=refrac_cnt-1.
- step_done<=1; → IDLE.
- spike_out/step_done are high exactly one cycle, 3 cycles after the edge that sampled step_end.

step_end outside IDLE:
- pending<=1.
- If pending is already 1: the pulse is dropped and overrun_flag<=1.

Reset mid-step:
- Aborts immediately; no spike_out or step_done is produced.

Test Plan:
- Reset: assert RESET_N low during LEAK with v_mem=3F400000 → v_mem=0, state IDLE, in_ready=1, all pulses/flags 0.
- Integration (LEAK overridden 32'h3E800000=0.25): weights 3F000000 excit, 3E800000 excit on consecutive cycles → v_mem=3F400000 after 2 edges; step_end → v_mem=3F000000; step_done 3 cycles later; no spike.
- Fire + refractory (LEAK=0.25):
  - 3F400000 twice → 3FC00000; step_end → 3FA00000, spike_out=1, v_mem=0.
  - Next 2 steps with 3F800000 inputs → discarded, no spike.
  - Third step with 3FC00000 → spike again.
- Inhibition/leak clamp (LEAK=0.25): 3F000000 inhibitory → BF000000; step → BE800000; step → 00000000; step → stays 00000000; no spikes.
- Collisions:
  - step_end and in_valid same cycle → in_ready=0; weight accepted the cycle after step_done.
  - step_end during LEAK → processed immediately after return to IDLE.
  - Third step_end while pending → overrun_flag=1.
- Exception: in_weight=7F800000 with v_mem=3F000000 and adder_exception=1 → v_mem stays 3F000000, exc_flag=1 until reset.

Source files
------------

// File: rtl/lif_potential_accumulator.sv
// lif_potential_accumulator: LIF membrane stage integrating FP32 spikes through an external combinational adder
module lif_potential_accumulator #(
    parameter logic [31:0] THRESHOLD    = 32'h3F800000,
    parameter logic [31:0] LEAK         = 32'h3DCCCCCD,
    parameter logic [31:0] V_RESET      = 32'h00000000,
    parameter int          REFRAC_STEPS = 2,
    parameter int          REFRAC_W     = 4
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_weight,
    input  logic        in_excit,
    input  logic        step_end,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    output logic        adder_sub,
    input  logic [31:0] adder_result,
    input  logic        adder_exception,
    output logic        spike_out,
    output logic        step_done,
    output logic [31:0] v_mem,
    output logic        exc_flag,
    output logic        overrun_flag
);
    typedef enum logic [1:0] {S_IDLE, S_LEAK, S_CHECK} state_t;

    state_t              state;
    logic [REFRAC_W-1:0] refrac_cnt;
    logic                pending;
    logic                accept;
    logic                fire;
    logic                v_zero;

    // handshake, threshold compare and adder operand selection
    always_comb begin
        in_ready  = (state == S_IDLE) && !step_end && !pending;
        accept    = in_valid && in_ready;
        v_zero    = (v_mem[30:0] == 31'd0);
        fire      = (refrac_cnt == '0) && !v_mem[31] && (v_mem[30:0] >= THRESHOLD[30:0]);
        adder_a   = v_mem;
        adder_b   = accept ? in_weight : (state == S_LEAK) ? LEAK : 32'h0;
        adder_sub = accept ? ~in_excit : (state == S_LEAK) ? ~v_mem[31] : 1'b0;
    end

    // accumulate / leak / check sequencer with one-deep step_end buffering
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= S_IDLE;
            v_mem        <= V_RESET;
            refrac_cnt   <= '0;
            pending      <= 1'b0;
            spike_out    <= 1'b0;
            step_done    <= 1'b0;
            exc_flag     <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            spike_out <= 1'b0;
            step_done <= 1'b0;
            if (state != S_IDLE && step_end) begin
                if (pending) overrun_flag <= 1'b1;
                else pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (accept && refrac_cnt == '0) begin
                        if (adder_exception) exc_flag <= 1'b1;
                        else v_mem <= adder_result;
                    end
                    if (step_end || pending) begin
                        state   <= S_LEAK;
                        pending <= pending && step_end;
                    end
                end
                S_LEAK: begin
                    if (!v_zero && refrac_cnt == '0) begin
                        if (adder_exception) exc_flag <= 1'b1;
                        else v_mem <= (adder_result[31] != v_mem[31]) ? 32'h0 : adder_result;
                    end
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (fire) begin
                        v_mem      <= V_RESET;
                        refrac_cnt <= REFRAC_W'(REFRAC_STEPS);
                        spike_out  <= 1'b1;
                    end else if (refrac_cnt != '0) begin
                        refrac_cnt <= refrac_cnt - 1'b1;
                    end
                    step_done <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
